// File: rtl/seq_alu_pkg.sv
// ============================================================================
// Module      : seq_alu_pkg
// Description : Opcode and FSM state encodings shared by the sequential ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_NOT  = 3'b101,
        OP_MUL  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/seq_alu_mul.sv
// ============================================================================
// Module      : seq_alu_mul
// Description : Unsigned shift-add multiplier, one multiplier bit per cycle,
//               LSB first, WIDTH iterations after load.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu_mul #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 last
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    logic                 r_run;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;

    // Accumulator value after the current iteration; on the last cycle this
    // is the complete product, so the parent can capture it on that edge.
    assign product = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign last    = r_run && (r_cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (load) begin
            r_run    <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
        end else if (r_run) begin
            r_acc    <= product;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_cnt == C_LAST) begin
                r_run <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// Module      : seq_alu
// Description : Sequential ALU: single-cycle ADD/SUB/logic ops and an
//               optional multi-cycle shift-add MUL (macro SEQ_ALU_MUL_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   result,
    output logic                 carry,
    output logic                 zero,
    output logic                 err,
    output logic                 busy,
    output logic                 done
);

    state_e              r_state;
    state_e              w_next_state;
    logic                w_accept;
    logic                w_mul_load;
    logic                w_mul_last;
    logic [2*WIDTH-1:0]  w_product;
    logic [WIDTH:0]      w_sum;
    logic [WIDTH:0]      w_diff;
    logic [WIDTH-1:0]    w_alu_res;
    logic                w_alu_carry;
    logic                w_alu_err;

    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign w_accept = (r_state == ST_IDLE) && start;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

`ifdef SEQ_ALU_MUL_EN
    assign w_mul_load = w_accept && (op == OP_MUL);

    seq_alu_mul #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (w_mul_load),
        .a       (a),
        .b       (b),
        .product (w_product),
        .last    (w_mul_last)
    );
`else
    assign w_mul_load = 1'b0;
    assign w_mul_last = 1'b0;
    assign w_product  = '0;
`endif

    // Without the multiplier, OP_MUL falls through to the reserved response.
    always_comb begin
        w_alu_res   = '0;
        w_alu_carry = 1'b0;
        w_alu_err   = 1'b0;
        case (op)
            OP_ADD: begin
                w_alu_res   = w_sum[WIDTH-1:0];
                w_alu_carry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_alu_res   = w_diff[WIDTH-1:0];
                w_alu_carry = w_diff[WIDTH];
            end
            OP_AND:  w_alu_res = a & b;
            OP_OR:   w_alu_res = a | b;
            OP_XOR:  w_alu_res = a ^ b;
            OP_NOT:  w_alu_res = ~a;
            default: w_alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_mul_load) begin
                    w_next_state = ST_MUL;
                end else if (start) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_MUL: begin
                if (w_mul_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b1;
            err    <= 1'b0;
        end else if (w_accept && !w_mul_load) begin
            result <= {{WIDTH{1'b0}}, w_alu_res};
            carry  <= w_alu_carry;
            zero   <= (w_alu_res == '0);
            err    <= w_alu_err;
        end else if ((r_state == ST_MUL) && w_mul_last) begin
            result <= w_product;
            carry  <= |w_product[2*WIDTH-1:WIDTH];
            zero   <= (w_product == '0);
            err    <= 1'b0;
        end
    end

endmodule

`default_nettype wire
